cc_unit: RTL and testbench
==========================

Name: cc_unit

Overview:
- Parametrised condition-code unit for the LC-3 datapath. It generalises the N/Z/P flag register to a WIDTH-bit bus.
- Adds direct NZP load, a registered branch-condition evaluator, and a DEPTH-entry save/restore stack. The stack holds CC across interrupt entry/RTI.
- Sits beside the PSR. It snoops the processor bus and feeds o_Br_Taken to the PC-mux control.

Parameters:
- WIDTH, 16, bus width; sign bit is WIDTH-1.
- DEPTH, 4, number of CC save-stack entries (>=1).
- CW, $clog2(DEPTH+1), width of o_Depth (derived, not overridable).

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Bus  input  WIDTH  processor bus value to classify.
- i_LD_CC  input  1  active-high; load NZP from classification of i_Bus.
- i_Set_NZP  input  1  active-high; load NZP directly from i_NZP_In.
- i_NZP_In  input  3  {N,Z,P} for direct load (PSR write path).
- i_Br_Eval  input  1  evaluate branch this cycle.
- i_Br_Mask  input  3  {n,z,p} mask from BR instruction bits [11:9].
- i_Push  input  1  save current NZP onto stack.
- i_Pop  input  1  restore NZP from stack top.
- o_N, o_Z, o_P  output  1 each  current condition codes.
- o_Br_Taken  output  1  registered branch decision.
- o_Depth  output  CW  number of valid stack entries.
- o_Stack_Full  output  1  o_Depth == DEPTH.
- o_Stack_Empty  output  1  o_Depth == 0.
- o_Overflow_Err  output  1  sticky: push attempted while full.
- o_Underflow_Err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (synchronous, overrides everything):
  - NZP = 3'b010 (Z=1).
  - o_Br_Taken = 0, o_Depth = 0, both error flags = 0.
  - Stack contents are don't-care.
- Classification of i_Bus, signed two's complement:
  - N = i_Bus[WIDTH-1].
  - Z = (i_Bus == 0).
  - P = !N && !Z.
  - Exactly one of N/Z/P is set after any classification load.
- NZP next-value priority, highest first: reset > pop (when not empty) > i_LD_CC > i_Set_NZP > hold.
- i_Set_NZP loads i_NZP_In verbatim; no one-hot check is performed.
- Push (i_Push=1, i_Pop=0):
  - Not full: writes the pre-update NZP (value at the start of the cycle) to entry[o_Depth], then o_Depth+1.
  - Same-cycle i_LD_CC still updates NZP.
  - Full: stack and o_Depth unchanged, o_Overflow_Err <= 1.
- Pop (i_Pop=1, i_Push=0):
  - Not empty: NZP <= entry[o_Depth-1], o_Depth-1. Pop overrides i_LD_CC and i_Set_NZP that cycle.
  - Empty: NZP follows LD_CC/Set/hold, o_Underflow_Err <= 1.
- Push and pop together:
  - Not empty: exchange. Top entry <= pre-update NZP, NZP <= old top, o_Depth unchanged.
  - Empty: treated as push only, no underflow flagged.
- Branch evaluation:
  - o_Br_Taken <= i_Br_Eval && |(i_Br_Mask & pre-update NZP).
  - Latency is 1 cycle. A same-cycle CC load does not affect that cycle's decision.
  - Mask 000 is never taken; mask 111 is always taken.
  - o_Br_Taken is 0 in any cycle following i_Br_Eval=0.
- Error flags are sticky; only i_Reset clears them.
- o_Stack_Full and o_Stack_Empty are combinational decodes of o_Depth.
- Reset asserted mid-sequence (stack non-empty) empties the stack in that cycle; earlier entries are unrecoverable.

Test Plan:
- Reset, then LD_CC with i_Bus=16'h8000, then 16'h0000, then 16'h7FFF -> NZP reads 100, 010, 001 on successive cycles; first cycle after reset reads 010.
- Load NZP=001, Br_Eval with mask 001 then 110 -> o_Br_Taken 1 then 0, each one cycle after eval. A same-cycle LD_CC to 16'hFFFF does not change the first decision.
- With DEPTH=4: push 4 times with NZP 100, 010, 001, 100 -> o_Stack_Full=1, o_Depth=4. 5th push -> o_Overflow_Err=1, o_Depth=4. 4 pops -> NZP 100, 001, 010, 100. 5th pop -> o_Underflow_Err=1, NZP unchanged.
- Pop concurrent with LD_CC(16'h0005) at depth 1 holding 100 -> NZP=100, o_Depth=0.
- Push+pop same cycle: depth 2, top=010, NZP=001 -> NZP=010, top=001, o_Depth=2. Same stimulus at depth 0 -> o_Depth=1, no underflow.
- Assert i_Reset at depth 3 with both error flags set -> next cycle o_Depth=0, flags 0, NZP=010, o_Stack_Empty=1. WIDTH=8 build: i_Bus=8'h80 gives N.

Source files
------------

// File: rtl/cc_unit.sv
`default_nettype none
// ============================================================================
// Module   : cc_unit
// Purpose  : LC-3 condition-code unit. Classifies the processor bus into
//            N/Z/P, allows direct NZP load from the PSR write path, evaluates
//            branch conditions (registered), and keeps a small save/restore
//            stack of NZP values for interrupt entry and RTI.
// Revision : 1.0  initial release
// ============================================================================
module cc_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Bus,
  input  logic             i_LD_CC,
  input  logic             i_Set_NZP,
  input  logic [2:0]       i_NZP_In,
  input  logic             i_Br_Eval,
  input  logic [2:0]       i_Br_Mask,
  input  logic             i_Push,
  input  logic             i_Pop,
  output logic             o_N,
  output logic             o_Z,
  output logic             o_P,
  output logic             o_Br_Taken,
  output logic [CW-1:0]    o_Depth,
  output logic             o_Stack_Full,
  output logic             o_Stack_Empty,
  output logic             o_Overflow_Err,
  output logic             o_Underflow_Err
);

  // Index width for the stack array; at least one bit even for DEPTH == 1.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_depth_max = CW'(DEPTH);
  localparam logic [2:0]    c_nzp_reset = 3'b010;

  logic [2:0]    r_nzp;
  logic [2:0]    r_stack [DEPTH];
  logic [CW-1:0] r_depth;
  logic          r_br_taken;
  logic          r_ovf;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic [2:0]    w_class;
  logic          w_neg;
  logic          w_zero;
  logic [CW-1:0] w_depth_m1;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_push_idx;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_exchange;
  logic          w_restore;
  logic          w_stack_we;
  logic [IW-1:0] w_stack_widx;
  logic [2:0]    w_nzp_next;

  // Classification, stack control decode and NZP next-value selection.
  always_comb begin
    w_full       = (r_depth == c_depth_max);
    w_empty      = (r_depth == '0);
    w_neg        = i_Bus[WIDTH-1];
    w_zero       = (i_Bus == '0);
    w_class      = {w_neg, w_zero, !w_neg && !w_zero};
    w_depth_m1   = r_depth - CW'(1);
    w_top_idx    = w_depth_m1[IW-1:0];
    w_push_idx   = r_depth[IW-1:0];
    // Push+pop on an empty stack degenerates to a plain push.
    w_do_push    = i_Push && (!i_Pop || w_empty) && !w_full;
    w_exchange   = i_Push && i_Pop && !w_empty;
    w_do_pop     = i_Pop && !i_Push && !w_empty;
    w_restore    = w_do_pop || w_exchange;
    w_stack_we   = w_do_push || w_exchange;
    w_stack_widx = w_exchange ? w_top_idx : w_push_idx;

    w_nzp_next = r_nzp;
    if (w_restore)      w_nzp_next = r_stack[w_top_idx];
    else if (i_LD_CC)   w_nzp_next = w_class;
    else if (i_Set_NZP) w_nzp_next = i_NZP_In;
  end

  // Flags, depth, branch decision and sticky errors.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_nzp      <= c_nzp_reset;
      r_depth    <= '0;
      r_br_taken <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_nzp      <= w_nzp_next;
      // Decision uses the NZP present at the start of the cycle.
      r_br_taken <= i_Br_Eval && |(i_Br_Mask & r_nzp);
      if (w_do_push)     r_depth <= r_depth + CW'(1);
      else if (w_do_pop) r_depth <= w_depth_m1;
      if (i_Push && !i_Pop && w_full)  r_ovf <= 1'b1;
      if (i_Pop && !i_Push && w_empty) r_unf <= 1'b1;
    end
  end

  // Stack storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && w_stack_we) r_stack[w_stack_widx] <= r_nzp;
  end

  // Output mapping.
  always_comb begin
    o_N             = r_nzp[2];
    o_Z             = r_nzp[1];
    o_P             = r_nzp[0];
    o_Br_Taken      = r_br_taken;
    o_Depth         = r_depth;
    o_Stack_Full    = w_full;
    o_Stack_Empty   = w_empty;
    o_Overflow_Err  = r_ovf;
    o_Underflow_Err = r_unf;
  end

endmodule
`default_nettype wire

// File: tb/tb_cc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_unit
// Purpose  : Directed self-checking bench for cc_unit (WIDTH=16 and WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_cc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus;
  logic        ld_cc, set_nzp, br_eval, push, pop;
  logic [2:0]  nzp_in, br_mask;
  logic        n, z, p, br_taken, full, empty, ovf, unf;
  logic [2:0]  depth;

  logic [7:0]  bus8;
  logic        ld8;
  logic        n8, z8, p8, bt8, full8, empty8, ovf8, unf8;
  logic [2:0]  depth8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_unit #(.WIDTH(16), .DEPTH(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Bus(bus), .i_LD_CC(ld_cc),
    .i_Set_NZP(set_nzp), .i_NZP_In(nzp_in), .i_Br_Eval(br_eval),
    .i_Br_Mask(br_mask), .i_Push(push), .i_Pop(pop),
    .o_N(n), .o_Z(z), .o_P(p), .o_Br_Taken(br_taken), .o_Depth(depth),
    .o_Stack_Full(full), .o_Stack_Empty(empty),
    .o_Overflow_Err(ovf), .o_Underflow_Err(unf)
  );

  cc_unit #(.WIDTH(8), .DEPTH(4)) dut8 (
    .i_Clk(clk), .i_Reset(rst), .i_Bus(bus8), .i_LD_CC(ld8),
    .i_Set_NZP(1'b0), .i_NZP_In(3'b000), .i_Br_Eval(1'b0),
    .i_Br_Mask(3'b000), .i_Push(1'b0), .i_Pop(1'b0),
    .o_N(n8), .o_Z(z8), .o_P(p8), .o_Br_Taken(bt8), .o_Depth(depth8),
    .o_Stack_Full(full8), .o_Stack_Empty(empty8),
    .o_Overflow_Err(ovf8), .o_Underflow_Err(unf8)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; bus = '0; ld_cc = 0; set_nzp = 0; nzp_in = '0;
    br_eval = 0; br_mask = '0; push = 0; pop = 0; bus8 = '0; ld8 = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic set_flags(input logic [2:0] v);
    idle(); set_nzp = 1; nzp_in = v; step(); idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({n, z, p} !== 3'b010) begin
      failures++; $display("FAIL reset_nzp got=%b exp=010", {n, z, p});
    end
    checks++;
    if ({br_taken, depth, full, empty, ovf, unf} !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got br=%b d=%0d f=%b e=%b o=%b u=%b exp br=0 d=0 f=0 e=1 o=0 u=0",
               br_taken, depth, full, empty, ovf, unf);
    end
  endtask

  task automatic test_classify();
    logic [15:0] vals [3] = '{16'h8000, 16'h0000, 16'h7FFF};
    logic [2:0]  exps [3] = '{3'b100, 3'b010, 3'b001};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); ld_cc = 1; bus = vals[i]; step();
      checks++;
      if ({n, z, p} !== exps[i]) begin
        failures++; $display("FAIL classify bus=%h got=%b exp=%b", vals[i], {n, z, p}, exps[i]);
      end
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    set_flags(3'b001);
    idle(); br_eval = 1; br_mask = 3'b001; step();
    checks++;
    if (br_taken !== 1'b1) begin
      failures++; $display("FAIL br_mask001 got=%b exp=1", br_taken);
    end
    idle(); br_eval = 1; br_mask = 3'b110; step();
    checks++;
    if (br_taken !== 1'b0) begin
      failures++; $display("FAIL br_mask110 got=%b exp=0", br_taken);
    end
    // Same-cycle load to negative must not influence this decision.
    idle(); br_eval = 1; br_mask = 3'b001; ld_cc = 1; bus = 16'hFFFF; step();
    checks++;
    if ({br_taken, n, z, p} !== 4'b1100) begin
      failures++; $display("FAIL br_same_cycle_ld got br=%b nzp=%b exp br=1 nzp=100", br_taken, {n, z, p});
    end
    idle(); br_eval = 1; br_mask = 3'b001; step();
    checks++;
    if (br_taken !== 1'b0) begin
      failures++; $display("FAIL br_after_ld got=%b exp=0", br_taken);
    end
    idle(); br_eval = 1; br_mask = 3'b111; step();
    checks++;
    if (br_taken !== 1'b1) begin
      failures++; $display("FAIL br_mask111 got=%b exp=1", br_taken);
    end
    idle(); br_eval = 1; br_mask = 3'b000; step();
    checks++;
    if (br_taken !== 1'b0) begin
      failures++; $display("FAIL br_mask000 got=%b exp=0", br_taken);
    end
    idle(); br_eval = 1; br_mask = 3'b111; step();
    idle(); br_eval = 0; br_mask = 3'b111; step();
    checks++;
    if (br_taken !== 1'b0) begin
      failures++; $display("FAIL br_no_eval got=%b exp=0", br_taken);
    end
    idle();
  endtask

  task automatic test_stack();
    logic [2:0] next_set [4] = '{3'b010, 3'b001, 3'b100, 3'b100};
    logic [2:0] pop_exp  [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    set_flags(3'b100);
    // Pushes store 100, 010, 001, 100 while loading the next value.
    for (int i = 0; i < 4; i++) begin
      idle(); push = 1; set_nzp = 1; nzp_in = next_set[i]; step();
    end
    idle();
    checks++;
    if ({full, empty, depth, ovf} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
      failures++; $display("FAIL stack_full got f=%b e=%b d=%0d o=%b exp f=1 e=0 d=4 o=0", full, empty, depth, ovf);
    end
    push = 1; step(); idle();
    checks++;
    if ({ovf, depth} !== {1'b1, 3'd4}) begin
      failures++; $display("FAIL overflow got o=%b d=%0d exp o=1 d=4", ovf, depth);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); pop = 1; step();
      checks++;
      if ({n, z, p} !== pop_exp[i] || depth !== 3'(3 - i)) begin
        failures++;
        $display("FAIL pop%0d got nzp=%b d=%0d exp nzp=%b d=%0d", i, {n, z, p}, depth, pop_exp[i], 3 - i);
      end
    end
    idle(); pop = 1; step(); idle();
    checks++;
    if ({unf, ovf, empty, depth, n, z, p} !== {1'b1, 1'b1, 1'b1, 3'd0, 3'b100}) begin
      failures++;
      $display("FAIL underflow got u=%b o=%b e=%b d=%0d nzp=%b exp u=1 o=1 e=1 d=0 nzp=100",
               unf, ovf, empty, depth, {n, z, p});
    end
  endtask

  task automatic test_pop_over_ld();
    do_reset();
    set_flags(3'b100);
    idle(); push = 1; step();
    set_flags(3'b010);
    idle(); pop = 1; ld_cc = 1; bus = 16'h0005; step(); idle();
    checks++;
    if ({n, z, p, depth, unf} !== {3'b100, 3'd0, 1'b0}) begin
      failures++; $display("FAIL pop_over_ld got nzp=%b d=%0d u=%b exp nzp=100 d=0 u=0", {n, z, p}, depth, unf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_flags(3'b100);
    idle(); push = 1; set_nzp = 1; nzp_in = 3'b010; step();
    idle(); push = 1; set_nzp = 1; nzp_in = 3'b001; step();
    idle(); push = 1; pop = 1; step(); idle();
    checks++;
    if ({n, z, p, depth} !== {3'b010, 3'd2}) begin
      failures++; $display("FAIL exchange got nzp=%b d=%0d exp nzp=010 d=2", {n, z, p}, depth);
    end
    pop = 1; step(); idle();
    checks++;
    if ({n, z, p, depth} !== {3'b001, 3'd1}) begin
      failures++; $display("FAIL exchange_top got nzp=%b d=%0d exp nzp=001 d=1", {n, z, p}, depth);
    end
    pop = 1; step(); idle();
    checks++;
    if ({n, z, p, depth} !== {3'b100, 3'd0}) begin
      failures++; $display("FAIL exchange_bottom got nzp=%b d=%0d exp nzp=100 d=0", {n, z, p}, depth);
    end
    do_reset();
    idle(); push = 1; pop = 1; step(); idle();
    checks++;
    if ({depth, unf, n, z, p} !== {3'd1, 1'b0, 3'b010}) begin
      failures++; $display("FAIL pushpop_empty got d=%0d u=%b nzp=%b exp d=1 u=0 nzp=010", depth, unf, {n, z, p});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(); pop = 1; step();
    for (int i = 0; i < 5; i++) begin
      idle(); push = 1; set_nzp = 1; nzp_in = 3'b001; step();
    end
    idle(); pop = 1; step(); idle();
    checks++;
    if ({depth, ovf, unf} !== {3'd3, 1'b1, 1'b1}) begin
      failures++; $display("FAIL pre_reset got d=%0d o=%b u=%b exp d=3 o=1 u=1", depth, ovf, unf);
    end
    rst = 1; push = 1; ld_cc = 1; bus = 16'h8000; step(); idle();
    checks++;
    if ({depth, ovf, unf, n, z, p, empty, full} !== {3'd0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset got d=%0d o=%b u=%b nzp=%b e=%b f=%b exp d=0 o=0 u=0 nzp=010 e=1 f=0",
               depth, ovf, unf, {n, z, p}, empty, full);
    end
  endtask

  task automatic test_width8();
    logic [7:0] vals [3] = '{8'h80, 8'h7F, 8'h00};
    logic [2:0] exps [3] = '{3'b100, 3'b001, 3'b010};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); ld8 = 1; bus8 = vals[i]; step();
      checks++;
      if ({n8, z8, p8} !== exps[i]) begin
        failures++; $display("FAIL w8_classify bus=%h got=%b exp=%b", vals[i], {n8, z8, p8}, exps[i]);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    test_reset();
    test_classify();
    test_branch();
    test_stack();
    test_pop_over_ld();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
